// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator: swaps S[i]/S[j], reads the keystream byte, and XORs it
// with the encrypted ROM byte into the decrypted RAM, one byte every 13 cycles.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_q,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] rom_address,
    output logic [MSG_AW-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic              busy,
    output logic              done
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J,
        WR_I, WR_J, RD_F, WT_F, CAP_F, WR_D, NEXT, DONE
    } state_t;

    state_t            state_q;
    logic [7:0]        i_q, j_q, si_q, sj_q, f_q, enc_q;
    logic [MSG_AW-1:0] k_q;
    logic [7:0]        s_address_q, s_data_q, dec_data_q;
    logic [MSG_AW-1:0] rom_address_q, dec_address_q;
    logic              s_wren_q, dec_wren_q, busy_q, done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            si_q          <= '0;
            sj_q          <= '0;
            f_q           <= '0;
            enc_q         <= '0;
            s_address_q   <= '0;
            s_data_q      <= '0;
            s_wren_q      <= 1'b0;
            rom_address_q <= '0;
            dec_address_q <= '0;
            dec_data_q    <= '0;
            dec_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RD_I;
                    end
                end
                RD_I: begin
                    i_q         <= i_q + 8'd1;
                    s_address_q <= i_q + 8'd1;
                    s_wren_q    <= 1'b0;
                    state_q     <= WT_I;
                end
                WT_I: state_q <= CAP_I;
                CAP_I: begin
                    si_q    <= s_q;
                    j_q     <= j_q + s_q;
                    state_q <= RD_J;
                end
                RD_J: begin
                    s_address_q <= j_q;
                    state_q     <= WT_J;
                end
                WT_J: state_q <= CAP_J;
                CAP_J: begin
                    sj_q    <= s_q;
                    state_q <= WR_I;
                end
                WR_I: begin
                    s_address_q <= i_q;
                    s_data_q    <= sj_q;
                    s_wren_q    <= 1'b1;
                    state_q     <= WR_J;
                end
                WR_J: begin
                    s_address_q <= j_q;
                    s_data_q    <= si_q;
                    s_wren_q    <= 1'b1;
                    state_q     <= RD_F;
                end
                // Issued after both swap writes, so it sees post-swap S even if si+sj hits i or j.
                RD_F: begin
                    s_wren_q      <= 1'b0;
                    s_address_q   <= si_q + sj_q;
                    rom_address_q <= k_q;
                    state_q       <= WT_F;
                end
                WT_F: state_q <= CAP_F;
                CAP_F: begin
                    f_q     <= s_q;
                    enc_q   <= rom_q;
                    state_q <= WR_D;
                end
                WR_D: begin
                    dec_address_q <= k_q;
                    dec_data_q    <= f_q ^ enc_q;
                    dec_wren_q    <= 1'b1;
                    state_q       <= NEXT;
                end
                NEXT: begin
                    dec_wren_q <= 1'b0;
                    if (k_q == K_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= RD_I;
                    end
                end
                DONE: begin
                    // Outputs return to zero on the way back to IDLE.
                    if (!start) begin
                        done_q        <= 1'b0;
                        s_address_q   <= '0;
                        s_data_q      <= '0;
                        rom_address_q <= '0;
                        dec_address_q <= '0;
                        dec_data_q    <= '0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_address   = s_address_q;
    assign s_data      = s_data_q;
    assign s_wren      = s_wren_q;
    assign rom_address = rom_address_q;
    assign dec_address = dec_address_q;
    assign dec_data    = dec_data_q;
    assign dec_wren    = dec_wren_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: two instances (MSG_LEN 3 and 9) with behavioural
// S RAM / ROM models and a queue of expected decrypted-RAM writes.
module tb_rc4_prga_decrypt;

    localparam int AW   = 5;
    localparam int LEN0 = 3;
    localparam int LEN1 = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_v   [2];
    logic [7:0] s_q_v     [2];
    logic [7:0] s_addr_v  [2];
    logic [7:0] s_data_v  [2];
    logic       s_wren_v  [2];
    logic [7:0] rom_q_v   [2];
    logic [AW-1:0] rom_addr_v [2];
    logic [AW-1:0] dec_addr_v [2];
    logic [7:0] dec_data_v[2];
    logic       dec_wren_v[2];
    logic       busy_v    [2];
    logic       done_v    [2];

    logic [7:0] s_mem   [2][256];
    logic [7:0] s_init  [2][256];
    logic [7:0] rom_mem [2][32];
    logic [7:0] model_s [256];
    logic       load_req[2];
    logic [15:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rc4_prga_decrypt #(.MSG_LEN(LEN0), .MSG_AW(AW)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_v[0]), .s_q(s_q_v[0]),
        .s_address(s_addr_v[0]), .s_data(s_data_v[0]), .s_wren(s_wren_v[0]),
        .rom_q(rom_q_v[0]), .rom_address(rom_addr_v[0]), .dec_address(dec_addr_v[0]),
        .dec_data(dec_data_v[0]), .dec_wren(dec_wren_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    rc4_prga_decrypt #(.MSG_LEN(LEN1), .MSG_AW(AW)) u_dut9 (
        .clk(clk), .reset(reset), .start(start_v[1]), .s_q(s_q_v[1]),
        .s_address(s_addr_v[1]), .s_data(s_data_v[1]), .s_wren(s_wren_v[1]),
        .rom_q(rom_q_v[1]), .rom_address(rom_addr_v[1]), .dec_address(dec_addr_v[1]),
        .dec_data(dec_data_v[1]), .dec_wren(dec_wren_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    // Synchronous-read memories; load_req copies a whole preset image into S.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (load_req[d]) begin
                for (int x = 0; x < 256; x++) s_mem[d][x] <= s_init[d][x];
            end else if (s_wren_v[d]) begin
                s_mem[d][s_addr_v[d]] <= s_data_v[d];
            end
            s_q_v[d]   <= s_mem[d][s_addr_v[d]];
            rom_q_v[d] <= rom_mem[d][rom_addr_v[d]];
        end
    end

    function automatic logic [37:0] outs(input int d);
        return {s_addr_v[d], s_data_v[d], s_wren_v[d], rom_addr_v[d], dec_addr_v[d],
                dec_data_v[d], dec_wren_v[d], busy_v[d], done_v[d]};
    endfunction

    task automatic load_s(input int d);
        @(negedge clk);
        load_req[d] = 1'b1;
        @(negedge clk);
        load_req[d] = 1'b0;
    endtask

    // Reference RC4 PRGA over the current S image; pushes expected writes, keeps final S.
    task automatic model_push(input int d, input int n);
        logic [7:0] ms[256];
        logic [7:0] mi, mj, t, fa;
        for (int x = 0; x < 256; x++) ms[x] = s_mem[d][x];
        mi = 8'd0;
        mj = 8'd0;
        for (int k = 0; k < n; k++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            t = ms[mi];
            ms[mi] = ms[mj];
            ms[mj] = t;
            fa = ms[mi] + ms[mj];
            exp_q.push_back({8'(k), ms[fa] ^ rom_mem[d][k]});
        end
        for (int x = 0; x < 256; x++) model_s[x] = ms[x];
    endtask

    task automatic drop_start(input int d);
        start_v[d] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_s_vs_model(input int d, input string name);
        int bad;
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[d][x] !== model_s[x]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s S contents: %0d entries differ, required 0", name, bad);
        end
    endtask

    // Raises start, runs until done, scoring dec writes and write-pulse/cycle counts.
    task automatic run_check(input int d, input int n, input string name);
        int iter, sw, sw_edges, dw;
        logic prev_sw;
        logic [15:0] item;
        bit got_done;
        @(negedge clk);
        start_v[d] = 1'b1;
        iter = 0; sw = 0; sw_edges = 0; dw = 0; prev_sw = 1'b0; got_done = 0;
        while (!got_done && iter < 13 * n + 40) begin
            @(negedge clk);
            iter++;
            if (iter == 1) begin
                checks++;
                if (busy_v[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy in RD_I: got %b, required 1", name, busy_v[d]);
                end
            end
            if (s_wren_v[d] === 1'b1) begin
                sw++;
                if (!prev_sw) sw_edges++;
            end
            prev_sw = (s_wren_v[d] === 1'b1);
            if (dec_wren_v[d] === 1'b1) begin
                dw++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected dec write addr=%0d data=%02h, required none",
                             name, dec_addr_v[d], dec_data_v[d]);
                end else begin
                    item = exp_q.pop_front();
                    if ({8'(dec_addr_v[d]), dec_data_v[d]} !== item) begin
                        errors++;
                        $display("FAIL %s dec write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 name, dec_addr_v[d], dec_data_v[d], item[15:8], item[7:0]);
                    end
                end
            end
            if (done_v[d] === 1'b1) got_done = 1;
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL %s timeout: done not seen after %0d cycles, required %0d", name, iter, 13 * n);
        end else begin
            checks++;
            if (iter - 1 != 13 * n || busy_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s run length: got %0d cycles busy=%b, required %0d cycles busy=0",
                         name, iter - 1, busy_v[d], 13 * n);
            end
        end
        checks++;
        if (sw != 2 * n || sw_edges != n || dw != n) begin
            errors++;
            $display("FAIL %s pulses: s_wren %0d cycles/%0d pulses dec_wren %0d, required %0d/%0d/%0d",
                     name, sw, sw_edges, dw, 2 * n, n, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing dec writes: got %0d left, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (outs(d) !== 38'd0) begin
                errors++;
                $display("FAIL reset outputs dut%0d: got %h, required 0", d, outs(d));
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_identity();
        for (int x = 0; x < 256; x++) s_init[0][x] = 8'(x);
        for (int x = 0; x < 32; x++) rom_mem[0][x] = 8'h00;
        load_s(0);
        exp_q.push_back({8'd0, 8'h02});
        exp_q.push_back({8'd1, 8'h05});
        exp_q.push_back({8'd2, 8'h07});
        run_check(0, LEN0, "identity");
        drop_start(0);
        checks++;
        if (s_mem[0][2] !== 8'h03 || s_mem[0][3] !== 8'h05 || s_mem[0][5] !== 8'h02) begin
            errors++;
            $display("FAIL identity S: got S2=%02h S3=%02h S5=%02h, required 03 05 02",
                     s_mem[0][2], s_mem[0][3], s_mem[0][5]);
        end
    endtask

    task automatic test_key();
        logic [23:0] sk;
        logic [7:0] key[3];
        logic [7:0] enc_tab[9];
        logic [7:0] pt_tab[9];
        logic [7:0] jj, t;
        sk = 24'h4B6579;
        key[0] = sk[23:16]; key[1] = sk[15:8]; key[2] = sk[7:0];
        enc_tab = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt_tab  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int x = 0; x < 256; x++) s_init[1][x] = 8'(x);
        jj = 8'd0;
        for (int x = 0; x < 256; x++) begin
            jj = jj + s_init[1][x] + key[x % 3];
            t = s_init[1][x];
            s_init[1][x] = s_init[1][jj];
            s_init[1][jj] = t;
        end
        for (int x = 0; x < 32; x++) rom_mem[1][x] = (x < 9) ? enc_tab[x] : 8'h00;
        load_s(1);
        for (int k = 0; k < 9; k++) exp_q.push_back({8'(k), pt_tab[k]});
        run_check(1, LEN1, "key_plaintext");
        drop_start(1);
    endtask

    task automatic test_i_eq_j();
        for (int x = 0; x < 256; x++) s_init[0][x] = 8'(x);
        s_init[0][1] = 8'h00;
        for (int x = 0; x < 32; x++) rom_mem[0][x] = 8'($urandom);
        load_s(0);
        model_push(0, LEN0);
        run_check(0, LEN0, "i_eq_j");
        drop_start(0);
        check_s_vs_model(0, "i_eq_j");
        checks++;
        if (s_mem[0][1] !== 8'h00) begin
            errors++;
            $display("FAIL i_eq_j S1: got %02h, required 00", s_mem[0][1]);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int x = 0; x < 256; x++) s_init[0][x] = 8'(255 - x);
        for (int x = 0; x < 32; x++) rom_mem[0][x] = 8'($urandom);
        load_s(0);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset busy before reset: got %b, required 1", busy_v[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs(0) !== 38'd0) begin
            errors++;
            $display("FAIL mid_reset outputs: got %h, required 0", outs(0));
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_push(0, LEN0);
        run_check(0, LEN0, "mid_reset_rerun");
        drop_start(0);
        check_s_vs_model(0, "mid_reset_rerun");
    endtask

    task automatic test_start_hold();
        for (int x = 0; x < 32; x++) rom_mem[0][x] = 8'($urandom);
        model_push(0, LEN0);
        run_check(0, LEN0, "hold_first");
        check_s_vs_model(0, "hold_first");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({done_v[0], busy_v[0], dec_wren_v[0], s_wren_v[0]} !== 4'b1000) begin
                errors++;
                $display("FAIL hold cycle %0d: got done=%b busy=%b dec_wren=%b s_wren=%b, required 1 0 0 0",
                         c, done_v[0], busy_v[0], dec_wren_v[0], s_wren_v[0]);
            end
        end
        start_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (outs(0) !== 38'd0) begin
            errors++;
            $display("FAIL hold idle outputs: got %h, required 0", outs(0));
        end
        model_push(0, LEN0);
        run_check(0, LEN0, "hold_restart");
        drop_start(0);
        check_s_vs_model(0, "hold_restart");
    endtask

    initial begin
        reset = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        load_req[0] = 1'b0;
        load_req[1] = 1'b0;
        test_reset();
        test_identity();
        test_key();
        test_i_eq_j();
        test_reset_mid_run();
        test_start_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
